// File: rtl/line_gen_bres_if.sv
// Command and pixel handshake bundle between the vector sequencer, the line
// rasteriser and the frame-buffer writer.
interface line_gen_bres_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] stax;
  logic [W-1:0] stay;
  logic [W-1:0] endx;
  logic [W-1:0] endy;
  logic         abort;
  logic         pix_valid;
  logic         pix_ready;
  logic [W-1:0] pix_x;
  logic [W-1:0] pix_y;
  logic         pix_last;
  logic         busy;

  modport master (
    output cmd_valid, stax, stay, endx, endy, abort, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_last, busy
  );

  modport slave (
    input  cmd_valid, stax, stay, endx, endy, abort, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_last, busy
  );
endinterface

// File: rtl/line_gen_bres.sv
// Bresenham line rasteriser: 1-cycle latency from command accept to start pixel.
// One pixel per cycle; pix_ready low stalls with all state held.
module line_gen_bres #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  line_gen_bres_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [W-1:0] ONE = 1;

  state_e              state_q, state_d;
  logic [W-1:0]        x_q, x_d, y_q, y_d;
  logic [W-1:0]        x1_q, x1_d, y1_q, y1_d;
  logic signed [W:0]   dx_q, dx_d, dy_q, dy_d;
  logic signed [W+1:0] err_q, err_d;
  logic                sxn_q, sxn_d, syn_q, syn_d;

  logic [W-1:0]        adx, ady;
  logic signed [W+1:0] dx_x2, dy_x2;
  logic signed [W+2:0] dx_x3, dy_x3, e2;
  logic                step_x, step_y, last_w;

  assign dx_x2  = {dx_q[W], dx_q};
  assign dy_x2  = {dy_q[W], dy_q};
  assign dx_x3  = {{2{dx_q[W]}}, dx_q};
  assign dy_x3  = {{2{dy_q[W]}}, dy_q};
  assign e2     = {err_q, 1'b0};
  assign step_x = (e2 >= dy_x3);
  assign step_y = (e2 <= dx_x3);
  assign adx    = (bus.endx >= bus.stax) ? bus.endx - bus.stax : bus.stax - bus.endx;
  assign ady    = (bus.endy >= bus.stay) ? bus.endy - bus.stay : bus.stay - bus.endy;

  // Gated by RUN so the all-zero reset registers never look like an end point.
  assign last_w = (state_q == RUN) && (x_q == x1_q) && (y_q == y1_q);

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.pix_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_last  = last_w;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          x_d     = bus.stax;
          y_d     = bus.stay;
          x1_d    = bus.endx;
          y1_d    = bus.endy;
          dx_d    = {1'b0, adx};
          dy_d    = -$signed({1'b0, ady});
          err_d   = {dx_d[W], dx_d} + {dy_d[W], dy_d};
          sxn_d   = (bus.endx < bus.stax);
          syn_d   = (bus.endy < bus.stay);
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.pix_ready) begin
          if (last_w) begin
            state_d = IDLE;
          end else begin
            err_d = err_q + (step_x ? dy_x2 : '0) + (step_y ? dx_x2 : '0);
            // Per-axis clamp keeps a coordinate parked once it reaches its end value.
            if (step_x && (x_q != x1_q)) x_d = sxn_q ? x_q - ONE : x_q + ONE;
            if (step_y && (y_q != y1_q)) y_d = syn_q ? y_q - ONE : y_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
    end
  end
endmodule
